dma_rx_buffer: RTL and testbench

- Downstream sink stage for the tiny DMA core; consumes its 7-bit data stream and its end-of-transfer (done) indication.
- Buffers accepted words in a small FIFO and presents them on a valid/ready output interface.
- Keeps a running per-frame 8-bit checksum, latched at end of frame, so the top level can expose transfer integrity on the pins.

---
 rtl/dma_rx_buffer.sv | 137 +++++++++++++
 tb/tb_dma_rx_buffer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dma_rx_buffer.sv
// Receive-side sink for the DMA core: word FIFO with valid/ready output, sticky overflow
// and a per-frame mod-256 checksum. Define DMA_RX_FRAME_LEN_EN to add the frame_len output.
module dma_rx_buffer #(
  parameter int DATA_W = 7,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        frame_sum,
`ifdef DMA_RX_FRAME_LEN_EN
  output logic [7:0]        frame_len,
`endif
  output logic              frame_done
);

  localparam int              CW      = ADDR_W + 1;
  localparam logic [ADDR_W:0] LP_FULL = DEPTH[ADDR_W:0];

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t            r_state, w_state_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [ADDR_W:0]   r_count, w_count_nxt, w_count_after_pop;
  logic [DATA_W-1:0] r_out_data;
  logic              r_overflow, r_frame_done;
  logic [7:0]        r_run_sum, r_frame_sum, w_sum_base, w_sum_incl;
  logic              w_full, w_pop, w_push, w_drop;
`ifdef DMA_RX_FRAME_LEN_EN
  logic [7:0]        r_run_len, r_frame_len, w_len_base, w_len_incl;
`endif

  function automatic logic [7:0] sum_add(input logic [7:0] acc, input logic [DATA_W-1:0] d);
    return acc + 8'(d);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    w_full            = (r_count == LP_FULL);
    w_pop             = out_valid & out_ready;
    w_push            = in_valid & (~w_full | w_pop);
    w_drop            = in_valid & w_full & ~w_pop;
    w_rd_nxt          = w_pop ? r_rd_ptr + ADDR_W'(1) : r_rd_ptr;
    w_count_after_pop = r_count - CW'(w_pop);
    w_count_nxt       = w_count_after_pop + CW'(w_push);
    // IDLE always starts a frame from zero, whatever the accumulator holds
    w_sum_base        = (r_state == S_IDLE) ? 8'd0 : r_run_sum;
    w_sum_incl        = w_push ? sum_add(w_sum_base, in_data) : w_sum_base;
`ifdef DMA_RX_FRAME_LEN_EN
    w_len_base        = (r_state == S_IDLE) ? 8'd0 : r_run_len;
    w_len_incl        = w_push ? sat_inc(w_len_base) : w_len_base;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!in_last && w_push) w_state_nxt = S_ACTIVE;
      S_ACTIVE: if (in_last)            w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_out_data   <= '0;
      r_overflow   <= 1'b0;
      r_run_sum    <= '0;
      r_frame_sum  <= '0;
      r_frame_done <= 1'b0;
`ifdef DMA_RX_FRAME_LEN_EN
      r_run_len    <= '0;
      r_frame_len  <= '0;
`endif
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_count_nxt;
      // Head register: next stored word, or the incoming word when it lands in an empty FIFO
      if (w_count_after_pop != '0) r_out_data <= r_mem[w_rd_nxt];
      else if (w_push)             r_out_data <= in_data;
      if (w_drop)       r_overflow <= 1'b1;
      else if (ovf_clr) r_overflow <= 1'b0;
      r_frame_done <= in_last;
      if (in_last) begin
        r_frame_sum <= w_sum_incl;
        r_run_sum   <= '0;
      end else begin
        r_run_sum   <= w_sum_incl;
      end
`ifdef DMA_RX_FRAME_LEN_EN
      if (in_last) begin
        r_frame_len <= w_len_incl;
        r_run_len   <= '0;
      end else begin
        r_run_len   <= w_len_incl;
      end
`endif
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = (r_count != '0);
  assign count      = r_count;
  assign overflow   = r_overflow;
  assign frame_sum  = r_frame_sum;
  assign frame_done = r_frame_done;
`ifdef DMA_RX_FRAME_LEN_EN
  assign frame_len  = r_frame_len;
`endif

endmodule

// File: tb/tb_dma_rx_buffer.sv
// Scoreboard bench for dma_rx_buffer: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_dma_rx_buffer;
  localparam int DATA_W = 7;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, overflow, frame_done;
  logic [ADDR_W:0]   count;
  logic [7:0]        frame_sum;
`ifdef DMA_RX_FRAME_LEN_EN
  logic [7:0]        frame_len;
`endif

  dma_rx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .count(count),
    .overflow(overflow), .ovf_clr(ovf_clr), .frame_sum(frame_sum),
`ifdef DMA_RX_FRAME_LEN_EN
    .frame_len(frame_len),
`endif
    .frame_done(frame_done)
  );

  typedef struct {
    int cnt; int ovf; int fsum; int flen; int fdone; int hold;
  } snap_t;

  int                n_pass = 0, n_total = 0;
  logic [DATA_W-1:0] sb[$];
  snap_t             pend, cur;
  bit                pend_ok = 0, pend_flush = 0, chk_en = 0;
  int                m_cnt = 0, m_ovf = 0, m_run = 0, m_len = 0;
  int                m_fsum = 0, m_flen = 0, m_fdone = 0, m_hold = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // One clock of stimulus; the model computes what the DUT should show after the next edge.
  task automatic cyc(input bit r, input bit iv, input logic [DATA_W-1:0] d,
                     input bit il, input bit ordy, input bit clr);
    bit pop, push, full, drop;
    int idx;
    @(posedge clk);
    #2;
    if (pend_ok) begin
      cur    = pend;
      chk_en = 1;
      if (pend_flush) sb.delete();
    end
    rst = r; in_valid = iv; in_data = d; in_last = il; out_ready = ordy; ovf_clr = clr;
    pend_flush = r;
    if (r) begin
      m_cnt = 0; m_ovf = 0; m_run = 0; m_len = 0;
      m_fsum = 0; m_flen = 0; m_fdone = 0; m_hold = 0;
    end else begin
      pop  = (m_cnt > 0) && ordy;
      full = (m_cnt == DEPTH);
      push = iv && (!full || pop);
      drop = iv && full && !pop;
      if (push) begin
        sb.push_back(d);
        m_run = (m_run + int'(d)) % 256;
        if (m_len < 255) m_len++;
      end
      m_cnt = m_cnt + int'(push) - int'(pop);
      m_ovf = drop ? 1 : (clr ? 0 : m_ovf);
      if (il) begin
        m_fsum = m_run; m_flen = m_len; m_fdone = 1; m_run = 0; m_len = 0;
      end else begin
        m_fdone = 0;
      end
      idx = pop ? 1 : 0;
      if (sb.size() > idx) m_hold = int'(sb[idx]);
    end
    pend.cnt = m_cnt; pend.ovf = m_ovf; pend.fsum = m_fsum;
    pend.flen = m_flen; pend.fdone = m_fdone; pend.hold = m_hold;
    pend_ok = 1;
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, ordy, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count", int'(count), cur.cnt);
      chk("out_valid", int'(out_valid), int'(cur.cnt != 0));
      chk("overflow", int'(overflow), cur.ovf);
      chk("frame_sum", int'(frame_sum), cur.fsum);
      chk("frame_done", int'(frame_done), cur.fdone);
`ifdef DMA_RX_FRAME_LEN_EN
      chk("frame_len", int'(frame_len), cur.flen);
`endif
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL out_data: got %0h with no word expected", out_data);
        end else begin
          chk("out_data", int'(out_data), int'(sb[0]));
          if (out_ready) void'(sb.pop_front());
        end
      end else begin
        chk("out_data_hold", int'(out_data), cur.hold);
      end
    end
  end

  initial begin
    cyc(1, 0, '0, 0, 0, 0);
    cyc(1, 0, '0, 0, 0, 0);
    idle(10, 1'b1);
    #4;
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_count", int'(count), 0);

    cyc(0, 1, 7'h05, 0, 0, 0);
    cyc(0, 1, 7'h7F, 0, 0, 0);
    #4;
    chk("first_word_latency", int'(out_data), 'h05);
    cyc(0, 1, 7'h10, 0, 0, 0);
    idle(1, 1'b0);
    #4;
    chk("three_pushed_count", int'(count), 3);
    idle(5, 1'b1);

    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 7'($urandom_range(127)), 0, 0, 0);
    cyc(0, 1, 7'h2A, 0, 0, 0);
    cyc(0, 0, '0, 0, 0, 1);
    #4;
    chk("drop_sets_overflow", int'(overflow), 1);
    chk("drop_count_full", int'(count), DEPTH);
    cyc(0, 1, 7'h33, 0, 1, 0);
    idle(1, 1'b0);
    #4;
    chk("ovf_clr_clears", int'(overflow), 0);
    chk("full_push_pop_count", int'(count), DEPTH);
    idle(10, 1'b1);

    cyc(0, 0, '0, 1, 1, 0);
    cyc(0, 1, 7'h7F, 0, 1, 0);
    cyc(0, 1, 7'h7F, 0, 1, 0);
    cyc(0, 1, 7'h03, 1, 1, 0);
    idle(1, 1'b1);
    #4;
    chk("frame_sum_wrap", int'(frame_sum), 'h01);
    chk("frame_done_pulse", int'(frame_done), 1);
`ifdef DMA_RX_FRAME_LEN_EN
    chk("frame_len_3", int'(frame_len), 3);
`endif
    cyc(0, 0, '0, 1, 1, 0);
    idle(1, 1'b1);
    #4;
    chk("empty_frame_sum", int'(frame_sum), 0);
    chk("empty_frame_done", int'(frame_done), 1);

    cyc(0, 1, 7'h11, 0, 0, 0);
    cyc(0, 1, 7'h22, 0, 0, 0);
    cyc(0, 1, 7'h33, 0, 0, 0);
    cyc(0, 1, 7'h44, 0, 0, 0);
    cyc(1, 0, '0, 0, 0, 0);
    idle(1, 1'b0);
    #4;
    chk("midframe_reset_count", int'(count), 0);
    chk("midframe_reset_valid", int'(out_valid), 0);
    cyc(0, 1, 7'h01, 1, 0, 0);
    idle(1, 1'b0);
    #4;
    chk("post_reset_frame_sum", int'(frame_sum), 'h01);
    idle(4, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      cyc($urandom_range(99) == 0, $urandom_range(1) == 1, 7'($urandom_range(127)),
          $urandom_range(9) == 0, $urandom_range(1) == 1, $urandom_range(19) == 0);
    end
    cyc(0, 0, '0, 0, 0, 1);
    idle(12, 1'b1);
    #4;
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
